// File: rtl/fpu_pkg.sv
// Shared FP32 constants, sequencer state encoding and small sign helpers
// used by the Newton-Raphson divide sequencer.
package fpu_pkg;

    localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;
    localparam logic [31:0] FP_ONE     = 32'h3F80_0000;
    localparam logic [31:0] FP_TWO     = 32'h4000_0000;
    localparam logic [31:0] NR_C0      = 32'h4034_B4B5;  // 48/17
    localparam logic [31:0] NR_C1      = 32'h3FF0_F0F1;  // 32/17

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_SEED_MUL,
        S_SEED_ADD,
        S_IT_MUL_DX,
        S_IT_ADD,
        S_IT_MUL_XE,
        S_SCALE,
        S_FINAL_MUL,
        S_DONE
    } nr_state_t;

    function automatic logic [31:0] fp_neg(input logic [31:0] v);
        return {~v[31], v[30:0]};
    endfunction

    function automatic logic [31:0] fp_inf(input logic s);
        return {s, FP_POS_INF[30:0]};
    endfunction

    function automatic logic [31:0] fp_zero(input logic s);
        return {s, 31'b0};
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational FP32 operand classifier; the sign bit plays no part, so only
// the magnitude field is taken.
module fp_classify (
    input  logic [30:0] mag,
    output logic        is_zero,
    output logic        is_inf,
    output logic        is_nan,
    output logic        is_sub
);

    logic exp_max;
    logic exp_min;
    logic man_zero;

    always_comb begin
        exp_max  = (mag[30:23] == 8'hFF);
        exp_min  = (mag[30:23] == 8'h00);
        man_zero = (mag[22:0] == 23'd0);
        is_zero  = exp_min && man_zero;
        is_sub   = exp_min && !man_zero;
        is_inf   = exp_max && man_zero;
        is_nan   = exp_max && !man_zero;
    end

endmodule

// File: rtl/fdiv_nr_seq.sv
// Newton-Raphson FP32 divide / reciprocal sequencer. Drives a shared
// multiplier and adder through start/done handshakes; holds no arithmetic.
module fdiv_nr_seq
    import fpu_pkg::*;
#(
    parameter int NR_ITERS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op_recip,
    input  logic [31:0] n1,
    input  logic [31:0] n2,
    output logic [31:0] result,
    output logic        done,
    output logic        busy,
    output logic        dz_flag,
    output logic        nv_flag,
    output logic        mul_start,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic        mul_done,
    input  logic [31:0] mul_result,
    output logic        add_start,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic        add_done,
    input  logic [31:0] add_result
);

    localparam int CW = (NR_ITERS > 0) ? $clog2(NR_ITERS + 1) : 1;
    localparam logic [CW-1:0] ITERS = CW'(NR_ITERS);

    nr_state_t      state;
    logic [CW-1:0]  cnt;
    logic [31:0]    n1_q;
    logic [31:0]    n2_q;
    logic           recip_q;
    logic [31:0]    x_q;

    logic [31:0]    d_val;
    logic           res_sign;

    logic           a_zero, a_inf, a_nan, a_sub;
    logic           b_zero, a_zf, b_inf, b_nan, b_sub, b_zf;

    logic           spc_hit;
    logic [31:0]    spc_val;
    logic           spc_dz;
    logic           spc_nv;

    logic signed [9:0] sc_exp;
    logic [31:0]       sc_val;

    // Reciprocal mode classifies n1 as +1.0 so the special rules are shared.
    fp_classify u_cls_a (
        .mag     (recip_q ? FP_ONE[30:0] : n1_q[30:0]),
        .is_zero (a_zero),
        .is_inf  (a_inf),
        .is_nan  (a_nan),
        .is_sub  (a_sub)
    );

    fp_classify u_cls_b (
        .mag     (n2_q[30:0]),
        .is_zero (b_zero),
        .is_inf  (b_inf),
        .is_nan  (b_nan),
        .is_sub  (b_sub)
    );

    always_comb begin
        d_val    = {1'b0, 8'd126, n2_q[22:0]};
        res_sign = recip_q ? n2_q[31] : (n1_q[31] ^ n2_q[31]);
        a_zf     = a_zero || a_sub;
        b_zf     = b_zero || b_sub;
    end

    always_comb begin
        spc_hit = 1'b1;
        spc_val = '0;
        spc_dz  = 1'b0;
        spc_nv  = 1'b0;
        if (a_nan || b_nan) begin
            spc_val = FP_QNAN;
        end else if ((a_zf && b_zf) || (a_inf && b_inf)) begin
            spc_val = FP_QNAN;
            spc_nv  = 1'b1;
        end else if (b_zf) begin
            spc_val = fp_inf(res_sign);
            spc_dz  = 1'b1;
        end else if (a_inf) begin
            spc_val = fp_inf(res_sign);
        end else if (a_zf || b_inf) begin
            spc_val = fp_zero(res_sign);
        end else begin
            spc_hit = 1'b0;
        end
    end

    // x approximates 1/D with D in [0.5,1); rebias by n2's exponent.
    always_comb begin
        sc_exp = $signed({2'b00, x_q[30:23]}) + 10'sd126
               - $signed({2'b00, n2_q[30:23]});
        if (sc_exp <= 10'sd0) begin
            sc_val = fp_zero(res_sign);
        end else if (sc_exp >= 10'sd255) begin
            sc_val = fp_inf(res_sign);
        end else begin
            sc_val = {res_sign, sc_exp[7:0], x_q[22:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            n1_q      <= '0;
            n2_q      <= '0;
            recip_q   <= 1'b0;
            x_q       <= '0;
            result    <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            dz_flag   <= 1'b0;
            nv_flag   <= 1'b0;
            mul_start <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            add_start <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
        end else begin
            mul_start <= 1'b0;
            add_start <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n1_q    <= n1;
                        n2_q    <= n2;
                        recip_q <= op_recip;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (spc_hit) begin
                        result  <= spc_val;
                        dz_flag <= spc_dz;
                        nv_flag <= spc_nv;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        mul_start <= 1'b1;
                        mul_a     <= d_val;
                        mul_b     <= NR_C1;
                        state     <= S_SEED_MUL;
                    end
                end
                S_SEED_MUL: begin
                    if (mul_done) begin
                        add_start <= 1'b1;
                        add_a     <= NR_C0;
                        add_b     <= fp_neg(mul_result);
                        state     <= S_SEED_ADD;
                    end
                end
                S_SEED_ADD: begin
                    if (add_done) begin
                        x_q <= add_result;
                        if (cnt < ITERS) begin
                            mul_start <= 1'b1;
                            mul_a     <= d_val;
                            mul_b     <= add_result;
                            state     <= S_IT_MUL_DX;
                        end else begin
                            state <= S_SCALE;
                        end
                    end
                end
                S_IT_MUL_DX: begin
                    if (mul_done) begin
                        add_start <= 1'b1;
                        add_a     <= FP_TWO;
                        add_b     <= fp_neg(mul_result);
                        state     <= S_IT_ADD;
                    end
                end
                S_IT_ADD: begin
                    if (add_done) begin
                        mul_start <= 1'b1;
                        mul_a     <= x_q;
                        mul_b     <= add_result;
                        state     <= S_IT_MUL_XE;
                    end
                end
                S_IT_MUL_XE: begin
                    if (mul_done) begin
                        x_q <= mul_result;
                        cnt <= cnt + 1'b1;
                        if ((cnt + 1'b1) < ITERS) begin
                            mul_start <= 1'b1;
                            mul_a     <= d_val;
                            mul_b     <= mul_result;
                            state     <= S_IT_MUL_DX;
                        end else begin
                            state <= S_SCALE;
                        end
                    end
                end
                S_SCALE: begin
                    if (recip_q) begin
                        result  <= sc_val;
                        dz_flag <= 1'b0;
                        nv_flag <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        mul_start <= 1'b1;
                        mul_a     <= {1'b0, n1_q[30:0]};
                        mul_b     <= sc_val;
                        state     <= S_FINAL_MUL;
                    end
                end
                S_FINAL_MUL: begin
                    if (mul_done) begin
                        result  <= {res_sign, mul_result[30:0]};
                        dz_flag <= 1'b0;
                        nv_flag <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fdiv_nr_seq.sv
// Bench for fdiv_nr_seq: behavioural FP32 multiplier/adder with random
// latency, handshake checker, and a real-arithmetic quotient reference.
module tb_fdiv_nr_seq;

    logic        clk = 1'b0;
    logic        rst, start, op_recip;
    logic [31:0] n1, n2;
    logic [31:0] result;
    logic        done, busy, dz_flag, nv_flag;
    logic        mul_start, add_start;
    logic [31:0] mul_a, mul_b, add_a, add_b;
    logic        mul_done, add_done;
    logic [31:0] mul_result, add_result;

    fdiv_nr_seq #(.NR_ITERS(3)) dut (
        .clk(clk), .rst(rst), .start(start), .op_recip(op_recip),
        .n1(n1), .n2(n2), .result(result), .done(done), .busy(busy),
        .dz_flag(dz_flag), .nv_flag(nv_flag),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_result(mul_result),
        .add_start(add_start), .add_a(add_a), .add_b(add_b),
        .add_done(add_done), .add_result(add_result)
    );

    always #5 clk = ~clk;

    localparam int RAND_ULP = 2;

    int checks   = 0;
    int failures = 0;
    int lat_lo   = 1;
    int lat_hi   = 6;
    int mul_cnt  = 0;
    int add_cnt  = 0;

    bit          m_busy = 0, m_stale = 0, m_moved = 0;
    bit          a_busy = 0, a_stale = 0, a_moved = 0;
    int          m_left, a_left;
    logic [31:0] m_a, m_b, a_a, a_b;

    logic [31:0] o_res;
    logic [1:0]  o_flags;
    int          o_cyc;
    logic        o_busy_done, o_done_after, o_busy_after;

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] b;
        if (f[30:23] == 8'h00)
            b = {f[31], 63'b0};
        else if (f[30:23] == 8'hFF)
            b = (f[22:0] != 0) ? 64'h7FF8_0000_0000_0000 : {f[31], 11'h7FF, 52'b0};
        else
            b = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'b0};
        return $bitstoreal(b);
    endfunction

    // Round-to-nearest-even, flush-to-zero conversion of a double to FP32.
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] b;
        logic [23:0] mr;
        int          e;
        b = $realtobits(r);
        if (b[62:52] == 11'h000) return {b[63], 31'b0};
        if (b[62:52] == 11'h7FF) return (b[51:0] != 0) ? 32'h7FC0_0000 : {b[63], 31'h7F80_0000};
        e  = int'(b[62:52]) - 896;
        mr = {1'b0, b[51:29]};
        if (b[28] && ((|b[27:0]) || b[29])) mr = mr + 24'd1;
        if (mr[23]) begin
            e  = e + 1;
            mr = '0;
        end
        if (e >= 255) return {b[63], 31'h7F80_0000};
        if (e <= 0) return {b[63], 31'b0};
        return {b[63], e[7:0], mr[22:0]};
    endfunction

    function automatic bit ulp_ok(input logic [31:0] g, input logic [31:0] e, input int tol);
        int d;
        if (g === e) return 1'b1;
        if (g[31] !== e[31]) return 1'b0;
        d = int'({1'b0, g[30:0]}) - int'({1'b0, e[30:0]});
        return (d <= tol) && (d >= -tol);
    endfunction

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_ulp(input string tag, input logic [31:0] got, input logic [31:0] exp,
                             input int tol);
        checks++;
        assert (ulp_ok(got, exp, tol) === 1'b1) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h (+-%0d ulp)", tag, got, exp, tol);
        end
    endtask

    // Unit models sample on negedge, so DUT requests are seen mid-cycle.
    always @(negedge clk) begin
        mul_done = 1'b0;
        add_done = 1'b0;
        if (rst && m_busy) m_stale = 1;
        if (rst && a_busy) a_stale = 1;
        if (m_busy) begin
            if (!m_stale && (mul_a !== m_a || mul_b !== m_b)) m_moved = 1;
            m_left--;
            if (m_left == 0) begin
                mul_done   = 1'b1;
                mul_result = r2f(f2r(m_a) * f2r(m_b));
                m_busy     = 0;
                if (!m_stale) begin
                    checks++;
                    assert (m_moved === 1'b0) else begin
                        failures++;
                        $error("FAIL mul_operands_stable got=moved exp=stable");
                    end
                end
            end
        end
        if (a_busy) begin
            if (!a_stale && (add_a !== a_a || add_b !== a_b)) a_moved = 1;
            a_left--;
            if (a_left == 0) begin
                add_done   = 1'b1;
                add_result = r2f(f2r(a_a) + f2r(a_b));
                a_busy     = 0;
                if (!a_stale) begin
                    checks++;
                    assert (a_moved === 1'b0) else begin
                        failures++;
                        $error("FAIL add_operands_stable got=moved exp=stable");
                    end
                end
            end
        end
        if (mul_start === 1'b1 || add_start === 1'b1) begin
            checks++;
            assert (!m_busy && !a_busy && !(mul_start && add_start)) else begin
                failures++;
                $error("FAIL single_outstanding got=m%0d a%0d exp=idle units", m_busy, a_busy);
            end
        end
        if (mul_start === 1'b1) begin
            mul_cnt++;
            m_busy = 1; m_stale = 0; m_moved = 0;
            m_left = int'($urandom_range(lat_hi, lat_lo));
            m_a = mul_a; m_b = mul_b;
        end
        if (add_start === 1'b1) begin
            add_cnt++;
            a_busy = 1; a_stale = 0; a_moved = 0;
            a_left = int'($urandom_range(lat_hi, lat_lo));
            a_a = add_a; a_b = add_b;
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic r);
        int cyc;
        mul_cnt = 0;
        add_cnt = 0;
        @(posedge clk); #1;
        n1 = a; n2 = b; op_recip = r; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 1;
        while (done !== 1'b1 && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check32("done_within_bound", {31'b0, done}, 32'd1);
        o_res       = result;
        o_flags     = {dz_flag, nv_flag};
        o_cyc       = cyc;
        o_busy_done = busy;
        @(posedge clk); #1;
        o_done_after = done;
        o_busy_after = busy;
    endtask

    logic [31:0] sp_a [11] = '{32'h7F800000, 32'h40000000, 32'h80000000, 32'hC0400000,
                               32'h7FC00001, 32'hFF800000, 32'h12345678, 32'h12345678,
                               32'h00400000, 32'h3F800000, 32'h00000000};
    logic [31:0] sp_b [11] = '{32'h40000000, 32'h7F800000, 32'h40400000, 32'h00000000,
                               32'h3F800000, 32'h7F800000, 32'h00000000, 32'hFF800000,
                               32'h3F800000, 32'h80000001, 32'h7F800001};
    logic        sp_r [11] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1};
    logic [31:0] sp_e [11] = '{32'h7F800000, 32'h00000000, 32'h80000000, 32'hFF800000,
                               32'h7FC00000, 32'h7FC00000, 32'h7F800000, 32'h80000000,
                               32'h00000000, 32'hFF800000, 32'h7FC00000};
    logic [1:0]  sp_f [11] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00,
                               2'b00, 2'b10, 2'b00};

    initial begin
        rst = 1'b1; start = 1'b0; op_recip = 1'b0; n1 = '0; n2 = '0;
        mul_done = 1'b0; add_done = 1'b0; mul_result = '0; add_result = '0;
        repeat (3) @(posedge clk);
        #1;
        check32("reset_result", result, 32'h0);
        check32("reset_ctl", {26'b0, done, busy, dz_flag, nv_flag, mul_start, add_start}, 32'h0);
        check32("reset_operands", mul_a | mul_b | add_a | add_b, 32'h0);
        rst = 1'b0;

        // 6 / 2
        run_op(32'h40C00000, 32'h40000000, 1'b0);
        check_ulp("div_6_2", o_res, 32'h40400000, 1);
        check32("div_6_2_flags", {30'b0, o_flags}, 32'h0);
        check32("div_6_2_busy_at_done", {31'b0, o_busy_done}, 32'd1);
        check32("div_6_2_done_once", {31'b0, o_done_after}, 32'd0);
        check32("div_6_2_busy_after", {31'b0, o_busy_after}, 32'd0);
        check32("div_6_2_held", result, 32'h40400000);
        check32("div_6_2_requests", mul_cnt + add_cnt, 32'd12);
        check32("div_6_2_mul_requests", mul_cnt, 32'd8);

        // reciprocal of 4.0
        run_op(32'hDEADBEEF, 32'h40800000, 1'b1);
        check32("recip_4", o_res, 32'h3E800000);
        check32("recip_4_requests", mul_cnt + add_cnt, 32'd11);
        check32("recip_4_mul_requests", mul_cnt, 32'd7);

        // 1 / 0 and 0 / 0
        run_op(32'h3F800000, 32'h00000000, 1'b0);
        check32("div_1_0", o_res, 32'h7F800000);
        check32("div_1_0_flags", {30'b0, o_flags}, 32'h2);
        check32("div_1_0_latency", o_cyc, 32'd2);
        check32("div_1_0_no_traffic", mul_cnt + add_cnt, 32'd0);
        run_op(32'h00000000, 32'h00000000, 1'b0);
        check32("div_0_0", o_res, 32'h7FC00000);
        check32("div_0_0_flags", {30'b0, o_flags}, 32'h1);
        check32("div_0_0_latency", o_cyc, 32'd2);
        check32("div_0_0_no_traffic", mul_cnt + add_cnt, 32'd0);

        // start held in the done cycle must be ignored
        @(posedge clk); #1;
        n1 = 32'h3F800000; n2 = 32'h00000000; op_recip = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check32("done_cycle_pulse", {31'b0, done}, 32'd1);
        start = 1'b1; n2 = 32'h40000000;
        @(posedge clk); #1;
        start = 1'b0;
        check32("start_in_done_ignored", {31'b0, busy}, 32'd0);

        // exponent clamps
        run_op(32'h7F000000, 32'h00800000, 1'b0);
        check32("overflow_clamp", o_res, 32'h7F800000);
        run_op(32'h00800000, 32'h7F000000, 1'b0);
        check32("underflow_clamp", o_res, 32'h00000000);

        // special-case table
        for (int i = 0; i < 11; i++) begin
            run_op(sp_a[i], sp_b[i], sp_r[i]);
            check32($sformatf("special_%0d", i), o_res, sp_e[i]);
            check32($sformatf("special_%0d_flags", i), {30'b0, o_flags}, {30'b0, sp_f[i]});
            check32($sformatf("special_%0d_traffic", i), mul_cnt + add_cnt, 32'd0);
        end

        // reset while the first iteration add is outstanding
        lat_lo = 6; lat_hi = 6; mul_cnt = 0; add_cnt = 0;
        @(posedge clk); #1;
        n1 = 32'h3F800000; n2 = 32'h40400000; op_recip = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 500 && add_cnt < 2; k++) begin
            @(posedge clk); #1;
        end
        check32("reached_it_add", add_cnt, 32'd2);
        rst = 1'b1;
        @(posedge clk); #1;
        check32("midrst_result", result, 32'h0);
        check32("midrst_ctl", {26'b0, done, busy, dz_flag, nv_flag, mul_start, add_start}, 32'h0);
        check32("midrst_operands", mul_a | mul_b | add_a | add_b, 32'h0);
        rst = 1'b0;
        for (int k = 0; k < 50 && a_busy; k++) begin
            @(posedge clk); #1;
        end
        check32("late_add_done_delivered", {31'b0, a_busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check32("late_done_ignored", {28'b0, busy, done, mul_start, add_start}, 32'h0);
        lat_lo = 1; lat_hi = 6;
        run_op(32'h3F800000, 32'h40400000, 1'b0);
        check_ulp("div_1_3_after_reset", o_res, 32'h3EAAAAAB, 1);

        // random normals against real-valued quotient
        lat_lo = 1; lat_hi = 2;
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] ra, rb, ex;
            logic        rr;
            ra = {1'($urandom_range(1, 0)), 8'($urandom_range(174, 80)), 23'($urandom)};
            rb = {1'($urandom_range(1, 0)), 8'($urandom_range(174, 80)), 23'($urandom)};
            rr = ($urandom_range(4, 0) == 0);
            ex = rr ? r2f(1.0 / f2r(rb)) : r2f(f2r(ra) / f2r(rb));
            run_op(ra, rb, rr);
            check_ulp($sformatf("random_%0d_%h_%h_r%0d", i, ra, rb, rr), o_res, ex, RAND_ULP);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
